fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter: DEPTH, 2, instruction queue slots; the maximum number of requests outstanding to memory.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: imem_req  output  1  fetch request valid.
REQ-006 Port: imem_addr  output  32  fetch address, word-aligned.
REQ-007 Port: imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 Port: imem_rvalid  input  1  read data valid; responses return in request order.
REQ-009 Port: imem_rdata  input  32  instruction word.
REQ-010 Port: redirect  input  1  branch/jump taken; flush and refetch.
REQ-011 Port: redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-012 Port: inst_valid  output  1  head instruction available to decode.
REQ-013 Port: inst  output  32  head instruction word.
REQ-014 Port: inst_pc  output  32  address of the head instruction.
REQ-015 Port: opcode  output  7  inst[6:0] when inst_valid=1, else 7'd0; feeds the decode controller.
REQ-016 Port: inst_ready  input  1  decode consumes the head this cycle.

Function
REQ-017 State: fetch PC; a DEPTH-entry in-order queue of slots {pc, data, filled}; a 2-bit drop counter.
REQ-018 imem_req = 1 iff not in a reset cycle, redirect=0, and occupancy + drop_cnt < DEPTH.
  - Occupancy is the registered value; a same-cycle pop gives no credit.
REQ-019 imem_addr = fetch PC; the address is held stable while imem_req=1 and imem_gnt=0.
REQ-020 Issue (imem_req && imem_gnt):
  - allocates a tail slot {pc=fetch PC, filled=0};
  - fetch PC += 4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-021 Response (imem_rvalid=1, redirect=0):
  - if drop_cnt>0: data discarded, drop_cnt decrements;
  - else: data written to the oldest unfilled slot, which is marked filled.
REQ-022 inst_valid = head slot filled and redirect=0; inst and inst_pc come from the head slot.
REQ-023 Pop: the head is removed on inst_valid && inst_ready; a pop and a fill/issue in the same cycle are all honoured.
REQ-024 Redirect cycle:
  - queue cleared; pop ignored; imem_req=0;
  - drop_cnt_next = drop_cnt + unfilled slots - (imem_rvalid ? 1 : 0);
  - fetch PC_next = {redirect_pc[31:2], 2'b00}.
REQ-025 Total requests outstanding to memory (unfilled slots + drop_cnt) never exceed DEPTH.
REQ-026 First request after a redirect is issued no earlier than the following cycle, at the redirect address.
REQ-027 imem_rvalid with no unfilled slot and drop_cnt=0 is a protocol error; it is ignored and state is unchanged.
REQ-028 Latency: grant in cycle N with rvalid in cycle N+k gives inst_valid=1 in cycle N+k+1 (registered fill).

Reset
REQ-029 While rst=1:
  - fetch PC=RESET_PC; queue empty; drop_cnt=0;
  - imem_req=0, inst_valid=0, opcode=7'd0, inst=0, inst_pc=0;
  - all inputs ignored.
REQ-030 Reset asserted mid-operation discards queue contents and outstanding responses; responses arriving after reset release fall under REQ-027.
REQ-031 First imem_req=1, with imem_addr=RESET_PC, occurs in the first cycle with rst=0.

Verification
REQ-032 Reset release, imem_gnt=1, 1-cycle memory:
  - requests at 0x0, then 0x4;
  - rdata 0x00000013 gives inst_valid=1, inst_pc=0x0, opcode=7'h13.
REQ-033 Backpressure:
  - inst_ready=0 with 2 slots filled -> imem_req=0 and address held;
  - inst_ready=1 for one cycle -> imem_req=1 the next cycle at the next sequential PC.
REQ-034 Redirect with 2 requests outstanding, redirect_pc=0x103:
  - next fetch is at 0x100;
  - the two old responses are dropped (drop_cnt 2->1->0), never shown on inst;
  - the first valid instruction has inst_pc=0x100.
REQ-035 Redirect coincident with imem_rvalid and inst_ready:
  - response discarded, pop ignored, inst_valid=0 that cycle;
  - drop_cnt equals outstanding minus 1.
REQ-036 Wrap-around, RESET_PC=32'hFFFF_FFFC: second request address is 32'h0000_0000.
REQ-037 rst pulse while 2 responses are outstanding, then stray imem_rvalid pulses:
  - ignored; inst_valid stays 0;
  - fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches to instruction memory and keeps an
// in-order queue of returned words for decode. Redirects flush the queue and drop stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  input  logic        inst_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc;
  logic [31:0]      slot_pc   [DEPTH];
  logic [31:0]      slot_data [DEPTH];
  logic [PTR_W-1:0] head;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] nfill;
  logic [1:0]       drop_cnt;

  logic [CNT_W-1:0] unfilled;
  logic [PTR_W-1:0] tail_idx;
  logic [PTR_W-1:0] fill_idx;
  logic             issue;
  logic             fill;
  logic             drop_rsp;
  logic             pop;
  int               drop_sum;
  logic [1:0]       drop_redir;
  logic             unused_rpc_lsb;

  function automatic logic [PTR_W-1:0] slot_idx(input logic [PTR_W-1:0] base,
                                                input logic [CNT_W-1:0] off);
    int s;
    s = (int'(base) + int'(off)) % DEPTH;
    return PTR_W'(s);
  endfunction

  // Filled slots always form a prefix of the queue, so the oldest unfilled slot sits at head+nfill.
  assign unfilled   = occ - nfill;
  assign tail_idx   = slot_idx(head, occ);
  assign fill_idx   = slot_idx(head, nfill);

  assign imem_req   = !rst && !redirect && ((int'(occ) + int'(drop_cnt)) < DEPTH);
  assign imem_addr  = rst ? RESET_PC : fetch_pc;
  assign inst_valid = !rst && !redirect && (nfill != '0);
  assign inst       = rst ? 32'd0 : slot_data[head];
  assign inst_pc    = rst ? 32'd0 : slot_pc[head];
  assign opcode     = inst_valid ? inst[6:0] : 7'd0;

  assign issue      = imem_req && imem_gnt;
  assign pop        = inst_valid && inst_ready;
  assign fill       = !rst && !redirect && imem_rvalid && (drop_cnt == 2'd0) && (nfill < occ);
  assign drop_rsp   = !rst && !redirect && imem_rvalid && (drop_cnt != 2'd0);

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // A response arriving in the redirect cycle retires one of the requests still owed by memory.
  always_comb begin
    drop_sum = int'(drop_cnt) + int'(unfilled);
    if (imem_rvalid && (drop_sum > 0))
      drop_sum = drop_sum - 1;
  end
  assign drop_redir = 2'(drop_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      occ      <= '0;
      nfill    <= '0;
      drop_cnt <= 2'd0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      head     <= '0;
      occ      <= '0;
      nfill    <= '0;
      drop_cnt <= drop_redir;
    end else begin
      if (issue)
        fetch_pc <= fetch_pc + 32'd4;
      if (pop)
        head <= slot_idx(head, CNT_W'(1));
      occ   <= occ + CNT_W'(issue) - CNT_W'(pop);
      nfill <= nfill + CNT_W'(fill) - CNT_W'(pop);
      if (drop_rsp)
        drop_cnt <= drop_cnt - 2'd1;
    end
  end

  // Slot payload carries no reset; occ/nfill decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (issue)
      slot_pc[tail_idx] <= fetch_pc;
    if (fill)
      slot_data[fill_idx] <= imem_rdata;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed protocol scenarios followed by randomized
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst, imem_gnt, imem_rvalid, redirect, inst_ready;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;
  logic [6:0]  opcode;
  logic        w_req, unused_w_valid;
  logic [31:0] w_addr, unused_w_inst, unused_w_pc;
  logic [6:0]  unused_w_op;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .opcode(opcode), .inst_ready(inst_ready));

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(unused_w_valid), .inst(unused_w_inst),
    .inst_pc(unused_w_pc), .opcode(unused_w_op), .inst_ready(inst_ready));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          filled;
  } slot_t;

  slot_t       q[$];
  logic [31:0] mem_q[$];
  logic [31:0] m_pc;
  int          m_drop;
  bit          e_req, e_valid;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs, then compare against the model's view of this cycle.
  task automatic look();
    logic [31:0] e_data;
    #3;
    e_req   = !rst && !redirect && ((q.size() + m_drop) < DEPTH);
    e_valid = !rst && !redirect && (q.size() > 0) && q[0].filled;
    e_data  = e_valid ? q[0].data : 32'd0;
    chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, e_valid});
    chk("opcode", {25'd0, opcode}, {25'd0, e_data[6:0]});
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    if (e_valid) begin
      chk("inst", inst, q[0].data);
      chk("inst_pc", inst_pc, q[0].pc);
    end
    if (rst) begin
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
    end
  endtask

  // Advance one clock and apply the fetch rules to the model.
  task automatic step();
    bit issue, pop;
    int unf, idx;
    @(posedge clk);
    issue = e_req && imem_gnt;
    pop   = e_valid && inst_ready;
    if (issue) mem_q.push_back(m_pc);
    if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (rst) begin
      m_pc = RST_PC; q.delete(); m_drop = 0;
    end else if (redirect) begin
      unf = 0;
      foreach (q[i]) if (!q[i].filled) unf++;
      m_drop = m_drop + unf;
      if (imem_rvalid && m_drop > 0) m_drop--;
      q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (imem_rvalid) begin
        if (m_drop > 0) m_drop--;
        else begin
          idx = -1;
          foreach (q[i]) if (idx < 0 && !q[i].filled) idx = i;
          if (idx >= 0) begin
            q[idx].data   = imem_rdata;
            q[idx].filled = 1'b1;
          end
        end
      end
      if (pop) void'(q.pop_front());
      if (issue) begin
        q.push_back('{pc: m_pc, data: 32'd0, filled: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic cyc();
    look();
    step();
  endtask

  task automatic idle_in();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'd0;
    redirect = 0; redirect_pc = 32'd0; inst_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_in();
    cyc();
    rst = 0;
  endtask

  initial begin
    rst = 1; idle_in();
    m_pc = RST_PC; m_drop = 0;

    // Reset state, then sequential fetch with a 1-cycle memory
    look();
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_valid", {31'd0, inst_valid}, 32'd0);
    chk("reset_opcode", {25'd0, opcode}, 32'd0);
    step();
    cyc();
    rst = 0; imem_gnt = 1;
    look();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    step();
    imem_rvalid = 1; imem_rdata = 32'h0000_0013;
    look();
    chk("second_addr", imem_addr, 32'h4);
    chk("wrap_second_req", {31'd0, w_req}, 32'd1);
    chk("wrap_second_addr", w_addr, 32'h0000_0000);
    step();
    imem_rdata = 32'h0010_0093;
    look();
    chk("first_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("first_inst_pc", inst_pc, 32'h0);
    chk("first_opcode", {25'd0, opcode}, 32'h13);
    chk("full_no_req", {31'd0, imem_req}, 32'd0);
    step();
    imem_rvalid = 0;
    look();
    chk("bp_req_low", {31'd0, imem_req}, 32'd0);
    chk("bp_addr_held", imem_addr, 32'h8);
    step();
    inst_ready = 1;
    look();
    chk("pop_no_credit", {31'd0, imem_req}, 32'd0);
    step();
    inst_ready = 0;
    look();
    chk("after_pop_req", {31'd0, imem_req}, 32'd1);
    chk("after_pop_addr", imem_addr, 32'h8);
    chk("after_pop_head", inst_pc, 32'h4);
    step();

    // Redirect with two requests outstanding
    do_reset();
    imem_gnt = 1;
    cyc(); cyc();
    imem_gnt = 0; redirect = 1; redirect_pc = 32'h0000_0103;
    look();
    chk("redir_req_low", {31'd0, imem_req}, 32'd0);
    step();
    redirect = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_0033;
    look();
    chk("redir_drop2_req", {31'd0, imem_req}, 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    step();
    imem_gnt = 1; imem_rdata = 32'hBEEF_0037;
    look();
    chk("redir_drop1_req", {31'd0, imem_req}, 32'd1);
    chk("redir_drop1_valid", {31'd0, inst_valid}, 32'd0);
    step();
    imem_gnt = 0; imem_rdata = 32'h0050_0093;
    look();
    chk("redir_stale_hidden", {31'd0, inst_valid}, 32'd0);
    step();
    imem_rvalid = 0; inst_ready = 1;
    look();
    chk("redir_first_valid", {31'd0, inst_valid}, 32'd1);
    chk("redir_first_pc", inst_pc, 32'h100);
    chk("redir_first_inst", inst, 32'h0050_0093);
    step();
    inst_ready = 0;
    cyc();

    // Redirect coinciding with a response and a pop
    do_reset();
    imem_gnt = 1;
    cyc();
    imem_rvalid = 1; imem_rdata = 32'h0000_0013;
    cyc();
    imem_gnt = 0; redirect = 1; redirect_pc = 32'h0000_0200;
    imem_rdata = 32'h0000_0073; inst_ready = 1;
    look();
    chk("coinc_valid_low", {31'd0, inst_valid}, 32'd0);
    step();
    redirect = 0; imem_rvalid = 0; inst_ready = 0; imem_gnt = 1;
    look();
    chk("coinc_req", {31'd0, imem_req}, 32'd1);
    chk("coinc_addr", imem_addr, 32'h200);
    step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0217;
    cyc();
    imem_rvalid = 0;
    look();
    chk("coinc_new_valid", {31'd0, inst_valid}, 32'd1);
    chk("coinc_new_pc", inst_pc, 32'h200);
    step();

    // Reset with responses outstanding, then stray responses
    do_reset();
    imem_gnt = 1;
    cyc(); cyc();
    imem_gnt = 0; rst = 1;
    cyc();
    rst = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0013;
    look();
    chk("rst_restart_addr", imem_addr, RST_PC);
    step();
    imem_rdata = 32'h0000_0067;
    cyc();
    imem_rvalid = 0;
    look();
    chk("stray_valid_low", {31'd0, inst_valid}, 32'd0);
    step();

    // Randomized traffic with an in-order memory of random latency
    do_reset();
    mem_q.delete();
    for (int n = 0; n < 1500; n++) begin
      imem_gnt    = ($urandom_range(0, 3) != 0);
      inst_ready  = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 39) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      if (mem_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        imem_rvalid = 1; imem_rdata = mem_word(mem_q[0]);
      end else begin
        imem_rvalid = 0; imem_rdata = $urandom;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
